// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin sharing of one uart_tx across N_REQ byte streams plus shadowed line config (UART_TX_SCHED_PRIO0_EN: requester 0 pre-empts).
// Latency: 1-cycle arbitration, 1-cycle config apply; backpressure: owner's ready follows tx_ready_i, all others held at 0.
module uart_tx_sched #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int IDW       = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ*8-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  input  logic               tx_busy_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic [IDW-1:0]     grant_id_o,
  input  logic               cfg_update_i,
  input  logic [15:0]        cfg_div_i,
  input  logic               cfg_parity_en_i,
  input  logic [1:0]         cfg_bits_i,
  input  logic               cfg_stop_bits_i,
  output logic [15:0]        cfg_div_o,
  output logic               cfg_parity_en_o,
  output logic [1:0]         cfg_bits_o,
  output logic               cfg_stop_bits_o,
  output logic               cfg_pending_o
);

  typedef enum logic [1:0] {IDLE, CFG, GRANT} state_e;

  typedef struct packed {
    logic [15:0] div;
    logic        parity_en;
    logic [1:0]  bits;
    logic        stop_bits;
  } cfg_t;

  localparam cfg_t CFG_RST = '{div: 16'd16, parity_en: 1'b0, bits: 2'b11, stop_bits: 1'b0};

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [7:0]       burst_q, burst_d;
  cfg_t             cfg_q, cfg_d;
  cfg_t             shadow_q, shadow_d;
  logic             pending_q, pending_d;

  logic [7:0]       req_byte [N_REQ];
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   win_idx;
  logic             win_vld;
  logic             xfer;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_byte[k] = req_data_i[8*k +: 8];
  end

  // Scan upward from the last owner so the previous winner is considered last.
  always_comb begin
    cand    = '0;
    win_idx = gid_q;
    win_vld = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDW'((int'(gid_q) + i) % N_REQ);
      if (!win_vld && req_valid_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
`ifdef UART_TX_SCHED_PRIO0_EN
    if (req_valid_i[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end
`else
`endif
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gid_d       = gid_q;
    burst_d     = burst_q;
    cfg_d       = cfg_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    tx_data_o   = '0;
    tx_valid_o  = 1'b0;
    req_ready_o = '0;
    xfer        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          if (!tx_busy_i) state_d = CFG;
        end else if (win_vld) begin
          grant_d = N_REQ'(1) << win_idx;
          gid_d   = win_idx;
          state_d = GRANT;
        end
      end
      CFG: begin
        cfg_d     = shadow_q;
        pending_d = 1'b0;
        state_d   = IDLE;
      end
      GRANT: begin
        tx_data_o          = req_byte[gid_q];
        tx_valid_o         = req_valid_i[gid_q];
        req_ready_o[gid_q] = tx_ready_i;
        xfer               = req_valid_i[gid_q] & tx_ready_i;
        if (xfer) begin
          if (req_last_i[gid_q] || burst_q == 8'(MAX_BURST - 1)) begin
            state_d = IDLE;
            grant_d = '0;
            burst_d = '0;
          end else begin
            burst_d = burst_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A capture landing in the CFG cycle keeps pending set so the newer value is applied next.
    if (cfg_update_i) begin
      shadow_d  = '{div: cfg_div_i, parity_en: cfg_parity_en_i,
                    bits: cfg_bits_i, stop_bits: cfg_stop_bits_i};
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gid_q     <= IDW'(N_REQ - 1);
      burst_q   <= '0;
      cfg_q     <= CFG_RST;
      shadow_q  <= CFG_RST;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gid_q     <= gid_d;
      burst_q   <= burst_d;
      cfg_q     <= cfg_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign grant_o         = grant_q;
  assign grant_id_o      = gid_q;
  assign cfg_div_o       = cfg_q.div;
  assign cfg_parity_en_o = cfg_q.parity_en;
  assign cfg_bits_o      = cfg_q.bits;
  assign cfg_stop_bits_o = cfg_q.stop_bits;
  assign cfg_pending_o   = pending_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requester byte queues feed the DUT, expected (byte, owner) pairs are queued by each scenario.
module tb_uart_tx_sched;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [N*8-1:0] req_data_i;
  logic [N-1:0] req_valid_i;
  logic [N-1:0] req_last_i;
  logic [N-1:0] req_ready_o;
  logic [7:0]   tx_data_o;
  logic         tx_valid_o;
  logic         tx_ready_i;
  logic         tx_busy_i;
  logic [N-1:0] grant_o;
  logic [1:0]   grant_id_o;
  logic         cfg_update_i;
  logic [15:0]  cfg_div_i;
  logic         cfg_parity_en_i;
  logic [1:0]   cfg_bits_i;
  logic         cfg_stop_bits_i;
  logic [15:0]  cfg_div_o;
  logic         cfg_parity_en_o;
  logic [1:0]   cfg_bits_o;
  logic         cfg_stop_bits_o;
  logic         cfg_pending_o;

  uart_tx_sched #(.N_REQ(N), .MAX_BURST(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_data_i(req_data_i), .req_valid_i(req_valid_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_busy_i(tx_busy_i),
    .grant_o(grant_o), .grant_id_o(grant_id_o),
    .cfg_update_i(cfg_update_i), .cfg_div_i(cfg_div_i), .cfg_parity_en_i(cfg_parity_en_i),
    .cfg_bits_i(cfg_bits_i), .cfg_stop_bits_i(cfg_stop_bits_i),
    .cfg_div_o(cfg_div_o), .cfg_parity_en_o(cfg_parity_en_o), .cfg_bits_o(cfg_bits_o),
    .cfg_stop_bits_o(cfg_stop_bits_o), .cfg_pending_o(cfg_pending_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
  } exp_t;

  exp_t         exp_q[$];
  logic [8:0]   src_q[N][$];   // {last, data}
  logic [N-1:0] fire;
  logic         alt_ready;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic src(input int k, input logic [7:0] d, input logic last);
    src_q[k].push_back({last, d});
  endtask

  task automatic expect_b(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back('{data: d, id: id});
  endtask

  task automatic flush();
    exp_q.delete();
    for (int k = 0; k < N; k++) src_q[k].delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    flush();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  // Returns at negedge+3 once at most 'left' expected transfers remain.
  task automatic wait_exp(input int left);
    int n = 0;
    while (exp_q.size() > left && n < 300) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("wait_exp_remaining", exp_q.size(), left);
  endtask

  // Requester model: present queue heads at negedge, retire on the accepting edge.
  always @(negedge clk) begin
    tx_ready_i = alt_ready ? ~tx_ready_i : 1'b1;
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        req_valid_i[k]        = 1'b1;
        req_data_i[8*k +: 8]  = src_q[k][0][7:0];
        req_last_i[k]         = src_q[k][0][8];
      end else begin
        req_valid_i[k]        = 1'b0;
        req_data_i[8*k +: 8]  = 8'h00;
        req_last_i[k]         = 1'b0;
      end
    end
    #1;
    fire = req_valid_i & req_ready_o;
    @(posedge clk);
    for (int k = 0; k < N; k++)
      if (fire[k] && !rst_i && src_q[k].size() > 0) src_q[k].delete(0);
  end

  // Monitor: every accepted byte must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_i && tx_valid_o && tx_ready_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_xfer: got data %0h id %0d, expected no transfer", tx_data_o, grant_id_o);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_data", {24'b0, tx_data_o}, {24'b0, e.data});
        chk("xfer_id", {30'b0, grant_id_o}, {30'b0, e.id});
        chk("xfer_grant", {28'b0, grant_o}, 32'(1) << e.id);
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    alt_ready = 1'b0;
    tx_ready_i = 1'b1;
    tx_busy_i = 1'b0;
    req_valid_i = '0;
    req_last_i = '0;
    req_data_i = '0;
    cfg_update_i = 1'b0;
    cfg_div_i = 16'd0;
    cfg_parity_en_i = 1'b0;
    cfg_bits_i = 2'b00;
    cfg_stop_bits_i = 1'b0;
    fire = '0;

    // Reset state
    do_reset();
    @(negedge clk); #3;
    chk("rst_grant", {28'b0, grant_o}, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid_o}, 32'h0);
    chk("rst_req_ready", {28'b0, req_ready_o}, 32'h0);
    chk("rst_grant_id", {30'b0, grant_id_o}, 32'd3);
    chk("rst_cfg", {12'b0, cfg_div_o, cfg_parity_en_o, cfg_bits_o, cfg_stop_bits_o},
        {12'b0, 16'd16, 1'b0, 2'b11, 1'b0});
    chk("rst_pending", {31'b0, cfg_pending_o}, 32'h0);

    // Two 3-byte frames, ready every other cycle
    alt_ready = 1'b1;
    src(1, 8'h11, 0); src(1, 8'h12, 0); src(1, 8'h13, 1);
    src(3, 8'h31, 0); src(3, 8'h32, 0); src(3, 8'h33, 1);
    expect_b(1, 8'h11); expect_b(1, 8'h12); expect_b(1, 8'h13);
    expect_b(3, 8'h31); expect_b(3, 8'h32); expect_b(3, 8'h33);
    wait_exp(3);
    @(negedge clk); #3;
    chk("gap_between_frames", {28'b0, grant_o}, 32'h0);
    wait_exp(0);

    // Round robin with single-byte frames from all requesters
    do_reset();
    alt_ready = 1'b0;
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < N; k++) begin
        src(k, 8'(8'h40 + 16*k + n), 1);
        expect_b(2'(k), 8'(8'h40 + 16*k + n));
      end
    wait_exp(0);

    // MAX_BURST release and re-grant, then frame lock with valid low
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      src(2, 8'(n), 0);
      expect_b(2, 8'(n));
    end
    wait_exp(4);
    @(negedge clk); #3;
    chk("burst_release", {28'b0, grant_o}, 32'h0);
    wait_exp(0);
    repeat (3) @(negedge clk);
    #3;
    chk("frame_lock_grant", {28'b0, grant_o}, 32'h4);
    chk("frame_lock_valid", {31'b0, tx_valid_o}, 32'h0);

    // Config update mid-frame while the transmitter is busy
    do_reset();
    alt_ready = 1'b1;
    tx_busy_i = 1'b1;
    src(0, 8'hA0, 0); src(0, 8'hA1, 0); src(0, 8'hA2, 1);
    expect_b(0, 8'hA0); expect_b(0, 8'hA1); expect_b(0, 8'hA2);
    wait_exp(2);
    cfg_div_i = 16'd434;
    cfg_parity_en_i = 1'b1;
    cfg_bits_i = 2'b10;
    cfg_stop_bits_i = 1'b1;
    cfg_update_i = 1'b1;
    @(negedge clk);
    cfg_update_i = 1'b0;
    #3;
    chk("cfg_pending_set", {31'b0, cfg_pending_o}, 32'h1);
    chk("cfg_div_held", {16'b0, cfg_div_o}, 32'd16);
    src(1, 8'h55, 1);
    wait_exp(0);
    repeat (3) @(negedge clk);
    #3;
    chk("cfg_busy_held", {12'b0, cfg_div_o, cfg_parity_en_o, cfg_bits_o, cfg_stop_bits_o},
        {12'b0, 16'd16, 1'b0, 2'b11, 1'b0});
    chk("no_grant_while_pending", {28'b0, grant_o}, 32'h0);
    @(negedge clk);
    tx_busy_i = 1'b0;
    alt_ready = 1'b0;
    @(negedge clk); #3;
    chk("cfg_cycle_pending", {31'b0, cfg_pending_o}, 32'h1);
    chk("cfg_cycle_div", {16'b0, cfg_div_o}, 32'd16);
    expect_b(1, 8'h55);
    @(negedge clk); #3;
    chk("cfg_applied", {12'b0, cfg_div_o, cfg_parity_en_o, cfg_bits_o, cfg_stop_bits_o},
        {12'b0, 16'd434, 1'b1, 2'b10, 1'b1});
    chk("cfg_pending_clr", {31'b0, cfg_pending_o}, 32'h0);
    wait_exp(0);

    // Asynchronous reset mid-grant
    for (int n = 0; n < 10; n++) begin
      src(2, 8'(8'h60 + n), 0);
      expect_b(2, 8'(8'h60 + n));
    end
    wait_exp(8);
    rst_i = 1'b1;
    #1;
    chk("arst_grant", {28'b0, grant_o}, 32'h0);
    chk("arst_tx_valid", {31'b0, tx_valid_o}, 32'h0);
    chk("arst_req_ready", {28'b0, req_ready_o}, 32'h0);
    chk("arst_grant_id", {30'b0, grant_id_o}, 32'd3);
    chk("arst_cfg", {12'b0, cfg_div_o, cfg_parity_en_o, cfg_bits_o, cfg_stop_bits_o},
        {12'b0, 16'd16, 1'b0, 2'b11, 1'b0});
    flush();
    @(negedge clk);
    rst_i = 1'b0;
    src(0, 8'h70, 1);
    src(2, 8'h72, 1);
    expect_b(0, 8'h70);
    expect_b(2, 8'h72);
    wait_exp(0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Front-end scheduler that shares one uart_tx instance between N_REQ byte-stream requesters. It grants the transmitter round-robin at frame boundaries and forwards the winner's valid/ready handshake. It also owns the UART line configuration: it holds it in a shadow register and applies updates only while the line is idle. It sits between the requester logic and the uart_tx data and config pins.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, max bytes per grant before forced release (1..255)
IDW, $clog2(N_REQ), grant index width (derived, not overridden)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
req_data_i  in  N_REQ*8  requester bytes; requester k uses bits [8k+7:8k]
req_valid_i  in  N_REQ  byte valid per requester
req_last_i  in  N_REQ  byte is last of frame
req_ready_o  out  N_REQ  byte accepted this cycle
tx_data_o  out  8  to uart_tx tx_data_i
tx_valid_o  out  1  to uart_tx tx_valid_i
tx_ready_i  in  1  from uart_tx tx_ready_o
tx_busy_i  in  1  from uart_tx busy_o
grant_o  out  N_REQ  one-hot current owner, 0 when none
grant_id_o  out  IDW  index of current/last owner
cfg_update_i  in  1  pulse: capture the cfg_*_i fields into the shadow register
cfg_div_i / cfg_parity_en_i / cfg_bits_i / cfg_stop_bits_i  in  16/1/2/1  new config
cfg_div_o / cfg_parity_en_o / cfg_bits_o / cfg_stop_bits_o  out  16/1/2/1  live config to uart_tx
cfg_pending_o  out  1  shadow captured, not yet applied

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; grant_o=0; grant_id_o=N_REQ-1, so requester 0 wins first; burst count=0.
  - cfg_div_o=16, cfg_parity_en_o=0, cfg_bits_o=2'b11, cfg_stop_bits_o=0; cfg_pending_o=0.
  - All outputs drop to these values immediately, mid-byte included. uart_tx is reset separately.
- FSM states: IDLE, CFG, GRANT.
- IDLE:
  - tx_valid_o=0, req_ready_o=0.
  - If cfg_pending_o=1: wait for tx_busy_i=0, then go to CFG. No grant is issued while a config is pending.
  - Else if any req_valid_i is set: pick the first valid index scanning upward from grant_id_o+1, with wrap-around. Register grant_o/grant_id_o and go to GRANT.
  - Arbitration latency is 1 cycle.
- CFG: copy the shadow into cfg_*_o, clear cfg_pending_o, return to IDLE. Lasts 1 cycle.
- GRANT (owner g):
  - Combinational pass-through: tx_data_o=req_data_i[g], tx_valid_o=req_valid_i[g], req_ready_o[g]=tx_ready_i; all other req_ready_o bits are 0.
  - A transfer occurs when tx_valid_o & tx_ready_i; each transfer increments the burst count.
  - Release to IDLE, clearing grant_o and the count, on a transfer with req_last_i[g]=1 or on the transfer that makes count == MAX_BURST.
  - grant_id_o keeps g after release.
  - Owner deasserting valid mid-frame: grant is held indefinitely (frame lock); no timeout.
- Config capture:
  - cfg_update_i=1 in any state loads the shadow and sets cfg_pending_o on the next edge.
  - A second update while pending overwrites the shadow; only the latest value is applied.
  - An update during GRANT applies only after the frame releases and tx_busy_i=0.
  - Update and release in the same cycle: IDLE then goes to CFG before any new grant.
- Fairness: a requester waits at most (N_REQ-1) grants.
- Single requester: re-granted after 1 IDLE cycle per burst.

Optional Feature:
- Macro UART_TX_SCHED_PRIO0_EN.
- Defined: in IDLE, requester 0 wins whenever req_valid_i[0]=1, overriding round-robin. It is still subject to MAX_BURST, and pending config still has precedence.
- Undefined: pure round-robin for all requesters.

Test Plan:
- Reset then idle -> cfg_div_o=16, cfg_bits_o=2'b11, grant_o=0, tx_valid_o=0, req_ready_o=0.
- Req1 and req3 both valid with 3-byte frames (0x11,0x12,0x13 last / 0x31,0x32,0x33 last), tx_ready_i=1 every other cycle -> tx_data_o sequence 11,12,13,31,32,33; grant_o 0010 then 1000; 1 idle cycle between frames.
- All 4 requesters valid continuously with last=1 on every byte -> grant_id_o sequence 0,1,2,3,0.
- Req2 sends 20 bytes, no last, MAX_BURST=16 -> release after byte 16, then a re-grant carries bytes 17-20.
- cfg_update_i with div=434 mid-frame while tx_busy_i=1 -> cfg_div_o stays 16 until the frame ends and busy=0, then becomes 434 in the CFG cycle; cfg_pending_o 1 -> 0.
- rst_i pulsed during GRANT mid-byte -> outputs return to reset values asynchronously; next grant goes to requester 0.
